regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
// Round-robin arbiter sharing the single register-file port (RD/RS1/RS2/REG_IN/REG_OUT1/2) among NUM_REQ
// execution units. Sits between the per-format units and the register file.
// Sequences each access as grant -> register-file access -> registered read-data response, one access per 2 cycles.
// PARAMETERS
// NUM_REQ  6   number of requesters (index 0..NUM_REQ-1)
// AW       5   register address width
// DW       32  register data width
// PORTS
// CLK            in   1            clock, all logic on rising edge
// RST_N          in   1            reset, asynchronous, active-low
// i_REQ          in   NUM_REQ      per-requester access request; held until o_GNT bit seen
// i_WE           in   NUM_REQ      per-requester write enable, qualifies i_RD/i_WDATA
// i_RD           in   NUM_REQ*AW   packed destination addresses (requester k at [k*AW +: AW])
// i_RS1          in   NUM_REQ*AW   packed source-1 addresses
// i_RS2          in   NUM_REQ*AW   packed source-2 addresses
// i_WDATA        in   NUM_REQ*DW   packed write data
// o_GNT          out  NUM_REQ      one-hot, registered; high for the single ACCESS cycle
// o_RVALID       out  NUM_REQ      one-hot, registered; high for the single RESP cycle
// o_RDATA1       out  DW           RS1 data, valid with o_RVALID
// o_RDATA2       out  DW           RS2 data, valid with o_RVALID
// o_X_RD         out  AW           to register file: write address
// o_X_RS1        out  AW           to register file: read address 1
// o_X_RS2        out  AW           to register file: read address 2
// o_X_WE         out  1            to register file: write strobe, sampled at end of ACCESS
// o_X_REG_IN     out  DW           to register file: write data
// i_X_REG_OUT1   in   DW           from register file: combinational read 1
// i_X_REG_OUT2   in   DW           from register file: combinational read 2
// o_BUSY         out  1            high in ACCESS or RESP
// BEHAVIOUR
// - Reset (RST_N low, async): state IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 has top priority.
// - FSM states: IDLE, ACCESS, RESP.
//   - IDLE -> ACCESS when |i_REQ.
//   - ACCESS -> RESP always.
//   - RESP -> ACCESS if |i_REQ, else IDLE.
// - Arbitration is combinational in IDLE/RESP.
//   - Winner = first set i_REQ bit searching from ptr+1 upward, wrapping NUM_REQ-1 -> 0.
//   - On the entering edge, latch winner index, set ptr = winner, o_GNT = onehot(winner).
//   - Register o_X_RD/RS1/RS2/REG_IN from the winner's slices.
//   - o_X_WE = i_WE[winner] && (i_RD slice != 0); writes to x0 are always suppressed.
// - ACCESS: o_X_* held stable and register file read combinationally.
//   - At end of cycle, capture i_X_REG_OUT1/2 into o_RDATA1/2 and set o_RVALID = o_GNT.
//   - Clear o_GNT, o_X_WE, and o_X_* to 0.
// - RESP: o_RVALID/o_RDATA valid for exactly 1 cycle; both cleared on leaving RESP. o_RDATA holds 0 otherwise.
// - Latency: request seen in IDLE -> o_GNT next cycle -> o_RVALID the cycle after (2 cycles).
// - Throughput: 1 grant per 2 cycles under continuous load.
// - Requester rules:
//   - Must drop i_REQ the cycle after it sees o_GNT; the arbiter never samples i_REQ in ACCESS.
//   - A request may be withdrawn before grant with no side effect.
// - Read/write same register in one access: o_RDATA is the pre-write value (read-before-write).
// - Single requester: granted every 2nd cycle regardless of pointer.
// - Reset mid-ACCESS/RESP: access abandoned.
//   - Write is not performed if reset asserts before the ACCESS-ending edge.
//   - No o_RVALID is issued.
// CONFIGURATION
// - Macro REGFILE_ARB_STATS_EN, when defined, adds output ports:
//   - o_GRANT_CNT [31:0]: total grants issued.
//   - o_CONFLICT_CNT [31:0]: arbitration edges with >1 i_REQ bit set.
//   - Both saturate at 32'hFFFFFFFF and reset to 0.
// - Without the macro these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - Package regfile_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), default widths AW/DW,
//   and a function extracting slice k from packed buses.
// - Sub-module rr_arbiter #(N): inputs req[N], ptr[$clog2(N)]; outputs gnt_onehot[N], gnt_idx, any.
//   Purely combinational; instanced once. The FSM, latches and counters stay in regfile_port_arbiter.
// TESTING
// 1. Reset, then i_REQ=6'b000001, RS1=3, RS2=4, REG_OUT1=0xAA, REG_OUT2=0xBB
//    -> o_GNT=000001 at cycle 1, o_RVALID=000001 with RDATA1=0xAA, RDATA2=0xBB at cycle 2.
// 2. All 6 requesting continuously, each dropping after its grant and re-raising 2 cycles later
//    -> grant order 0,1,2,3,4,5,0 on every 2nd cycle; o_BUSY stays 1.
// 3. Requester 2 with WE=1, RD=0, WDATA=0x1234 -> o_X_WE stays 0 throughout the access.
// 4. Requester 1 with WE=1, RD=RS1=7, old x7=0x5, WDATA=0x9
//    -> o_RDATA1=0x5; a following read of x7 returns 0x9.
// 5. RST_N pulled low in the middle of ACCESS
//    -> o_GNT/o_X_WE drop immediately, no o_RVALID, next request is granted to requester 0 first.
// 6. With REGFILE_ARB_STATS_EN, 3 simultaneous requests
//    -> o_GRANT_CNT=3, o_CONFLICT_CNT=2 after all three are served.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file port arbiter: state encoding,
// default widths and a packed-bus slice extractor.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int ARB_AW      = 5;
    localparam int ARB_DW      = 32;
    localparam int SLICE_BUS_W = 256;

    // Returns field k of width w (w <= 32) from a bus of w-wide fields packed LSB-first.
    function automatic logic [31:0] bus_slice(input logic [SLICE_BUS_W-1:0] bus,
                                              input int unsigned k,
                                              input int unsigned w);
        logic [SLICE_BUS_W-1:0] shifted;
        logic [31:0]            mask;
        shifted = bus >> (k * w);
        if (w >= 32'd32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << w) - 32'd1;
        end
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N  = 6,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic          found_s;
    logic [IW-1:0] cand_s;

    // Scan candidates ptr+1 .. ptr+N (mod N) and keep the first requester hit.
    always_comb begin
        found_s = 1'b0;
        gnt_idx = '0;
        cand_s  = '0;
        for (int i = 1; i <= N; i++) begin
            cand_s = IW'((int'(ptr) + i) % N);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                gnt_idx = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign gnt_onehot = found_s ? (N'(1) << gnt_idx) : '0;
    assign any        = |req;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one register-file port among NUM_REQ units: grant -> access -> response.
// Optional grant/conflict counters are built when REGFILE_ARB_STATS_EN is defined.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 6,
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NUM_REQ-1:0]    i_REQ,
    input  logic [NUM_REQ-1:0]    i_WE,
    input  logic [NUM_REQ*AW-1:0] i_RD,
    input  logic [NUM_REQ*AW-1:0] i_RS1,
    input  logic [NUM_REQ*AW-1:0] i_RS2,
    input  logic [NUM_REQ*DW-1:0] i_WDATA,
    output logic [NUM_REQ-1:0]    o_GNT,
    output logic [NUM_REQ-1:0]    o_RVALID,
    output logic [DW-1:0]         o_RDATA1,
    output logic [DW-1:0]         o_RDATA2,
    output logic [AW-1:0]         o_X_RD,
    output logic [AW-1:0]         o_X_RS1,
    output logic [AW-1:0]         o_X_RS2,
    output logic                  o_X_WE,
    output logic [DW-1:0]         o_X_REG_IN,
    input  logic [DW-1:0]         i_X_REG_OUT1,
    input  logic [DW-1:0]         i_X_REG_OUT2,
    output logic                  o_BUSY
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [31:0]           o_GRANT_CNT,
    output logic [31:0]           o_CONFLICT_CNT
`endif
);

    localparam int            IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
    logic [DW-1:0]        rdata1_q, rdata1_d;
    logic [DW-1:0]        rdata2_q, rdata2_d;
    logic [AW-1:0]        x_rd_q, x_rd_d;
    logic [AW-1:0]        x_rs1_q, x_rs1_d;
    logic [AW-1:0]        x_rs2_q, x_rs2_d;
    logic                 x_we_q, x_we_d;
    logic [DW-1:0]        x_reg_in_q, x_reg_in_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   win_onehot_s;
    logic [IW-1:0]        win_idx_s;
    logic                 any_s;
    logic [AW-1:0]        win_rd_s, win_rs1_s, win_rs2_s;
    logic [DW-1:0]        win_wdata_s;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req        (i_REQ),
        .ptr        (ptr_q),
        .gnt_onehot (win_onehot_s),
        .gnt_idx    (win_idx_s),
        .any        (any_s)
    );

    assign win_rd_s    = AW'(bus_slice(SLICE_BUS_W'(i_RD),    32'(win_idx_s), AW));
    assign win_rs1_s   = AW'(bus_slice(SLICE_BUS_W'(i_RS1),   32'(win_idx_s), AW));
    assign win_rs2_s   = AW'(bus_slice(SLICE_BUS_W'(i_RS2),   32'(win_idx_s), AW));
    assign win_wdata_s = DW'(bus_slice(SLICE_BUS_W'(i_WDATA), 32'(win_idx_s), DW));

    // Next-state and next-output logic; everything not explicitly driven returns to 0.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        rvalid_d   = '0;
        rdata1_d   = '0;
        rdata2_d   = '0;
        x_rd_d     = '0;
        x_rs1_d    = '0;
        x_rs2_d    = '0;
        x_we_d     = 1'b0;
        x_reg_in_d = '0;
        case (state_q)
            IDLE, RESP: begin
                if (any_s) begin
                    state_d    = ACCESS;
                    ptr_d      = win_idx_s;
                    gnt_d      = win_onehot_s;
                    x_rd_d     = win_rd_s;
                    x_rs1_d    = win_rs1_s;
                    x_rs2_d    = win_rs2_s;
                    x_reg_in_d = win_wdata_s;
                    // x0 is architecturally zero, so writes to it never reach the file
                    x_we_d     = i_WE[win_idx_s] && (win_rd_s != '0);
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d  = RESP;
                rvalid_d = gnt_q;
                rdata1_d = i_X_REG_OUT1;
                rdata2_d = i_X_REG_OUT2;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM state, round-robin pointer and all registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_RST;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            x_rd_q     <= '0;
            x_rs1_q    <= '0;
            x_rs2_q    <= '0;
            x_we_q     <= 1'b0;
            x_reg_in_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            x_rd_q     <= x_rd_d;
            x_rs1_q    <= x_rs1_d;
            x_rs2_q    <= x_rs2_d;
            x_we_q     <= x_we_d;
            x_reg_in_q <= x_reg_in_d;
            busy_q     <= busy_d;
        end
    end

    assign o_GNT      = gnt_q;
    assign o_RVALID   = rvalid_q;
    assign o_RDATA1   = rdata1_q;
    assign o_RDATA2   = rdata2_q;
    assign o_X_RD     = x_rd_q;
    assign o_X_RS1    = x_rs1_q;
    assign o_X_RS2    = x_rs2_q;
    assign o_X_WE     = x_we_q;
    assign o_X_REG_IN = x_reg_in_q;
    assign o_BUSY     = busy_q;

`ifdef REGFILE_ARB_STATS_EN
    localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);
    localparam logic [31:0]        CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;
    logic        arb_edge_s;
    logic        multi_req_s;

    assign arb_edge_s  = (state_q == IDLE) || (state_q == RESP);
    assign multi_req_s = (i_REQ & (i_REQ - REQ_ONE)) != '0;

    // Saturating counters, stepped only on edges where arbitration happens.
    always_comb begin
        if (arb_edge_s && any_s && (grant_cnt_q != CNT_MAX)) begin
            grant_cnt_d = grant_cnt_q + 32'd1;
        end else begin
            grant_cnt_d = grant_cnt_q;
        end
        if (arb_edge_s && multi_req_s && (conflict_cnt_q != CNT_MAX)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            grant_cnt_q    <= 32'd0;
            conflict_cnt_q <= 32'd0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign o_GRANT_CNT    = grant_cnt_q;
    assign o_CONFLICT_CNT = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level model with its own register copy.
module tb_regfile_port_arbiter;

    localparam int N  = 6;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [N-1:0]    req, we;
    logic [AW-1:0]   rd_a [N];
    logic [AW-1:0]   rs1_a [N];
    logic [AW-1:0]   rs2_a [N];
    logic [DW-1:0]   wd_a [N];
    logic [N*AW-1:0] rd_bus, rs1_bus, rs2_bus;
    logic [N*DW-1:0] wd_bus;

    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata1, rdata2, x_in, reg_out1, reg_out2;
    logic [AW-1:0]   x_rd, x_rs1, x_rs2;
    logic            x_we, busy;
`ifdef REGFILE_ARB_STATS_EN
    logic [31:0]     gcnt, ccnt;
`endif

    logic [DW-1:0]   rf [32];
    logic [DW-1:0]   ref_regs [32];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign rd_bus [g*AW +: AW] = rd_a[g];
        assign rs1_bus[g*AW +: AW] = rs1_a[g];
        assign rs2_bus[g*AW +: AW] = rs2_a[g];
        assign wd_bus [g*DW +: DW] = wd_a[g];
    end

    assign reg_out1 = rf[x_rs1];
    assign reg_out2 = rf[x_rs2];

    regfile_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .i_REQ        (req),
        .i_WE         (we),
        .i_RD         (rd_bus),
        .i_RS1        (rs1_bus),
        .i_RS2        (rs2_bus),
        .i_WDATA      (wd_bus),
        .o_GNT        (gnt),
        .o_RVALID     (rvalid),
        .o_RDATA1     (rdata1),
        .o_RDATA2     (rdata2),
        .o_X_RD       (x_rd),
        .o_X_RS1      (x_rs1),
        .o_X_RS2      (x_rs2),
        .o_X_WE       (x_we),
        .o_X_REG_IN   (x_in),
        .i_X_REG_OUT1 (reg_out1),
        .i_X_REG_OUT2 (reg_out2),
        .o_BUSY       (busy)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .o_GRANT_CNT    (gcnt),
        .o_CONFLICT_CNT (ccnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding access, pointer, captured operands.
    bit            m_acc, m_resp;
    int            m_ptr, m_win;
    logic [AW-1:0] m_rd, m_rs1, m_rs2;
    logic          m_we_eff;
    logic [DW-1:0] m_wd;
    int unsigned   m_grants, m_conflicts;
    logic [N-1:0]  e_gnt, e_rvalid;
    logic [DW-1:0] e_rdata1, e_rdata2, e_xin;
    logic [AW-1:0] e_xrd, e_xrs1, e_xrs2;
    logic          e_xwe, e_busy;

    bit            rand_en, rearm_en;
    int            rearm [N];
    logic          pw_en;
    logic [AW-1:0] pw_a;
    logic [DW-1:0] pw_d;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic predict();
        int         cnt;
        logic [2:0] wi;
        if (m_acc) begin
            wi       = 3'(m_win);
            e_rvalid = 6'b000001 << wi;
            e_rdata1 = ref_regs[m_rs1];
            e_rdata2 = ref_regs[m_rs2];
            if (m_we_eff) ref_regs[m_rd] = m_wd;
            e_gnt = '0; e_xwe = 1'b0; e_xrd = '0; e_xrs1 = '0; e_xrs2 = '0; e_xin = '0;
            m_acc  = 1'b0;
            m_resp = 1'b1;
        end else begin
            e_rvalid = '0; e_rdata1 = '0; e_rdata2 = '0;
            m_resp = 1'b0;
            cnt = $countones(req);
            if (cnt > 1) m_conflicts++;
            if (cnt > 0) begin
                m_win = -1;
                for (int i = 1; i <= N; i++) begin
                    if (m_win < 0 && ((req >> ((m_ptr + i) % N)) & 6'd1) != 6'd0)
                        m_win = (m_ptr + i) % N;
                end
                m_ptr    = m_win;
                wi       = 3'(m_win);
                e_gnt    = 6'b000001 << wi;
                e_xrd    = rd_a[wi];
                e_xrs1   = rs1_a[wi];
                e_xrs2   = rs2_a[wi];
                e_xin    = wd_a[wi];
                e_xwe    = we[wi] && (rd_a[wi] != 5'd0);
                m_rd     = rd_a[wi];
                m_rs1    = rs1_a[wi];
                m_rs2    = rs2_a[wi];
                m_wd     = wd_a[wi];
                m_we_eff = e_xwe;
                m_acc    = 1'b1;
                m_grants++;
            end else begin
                e_gnt = '0; e_xwe = 1'b0; e_xrd = '0; e_xrs1 = '0; e_xrs2 = '0; e_xin = '0;
            end
        end
        e_busy = m_acc | m_resp;
    endtask

    task automatic compare();
        check_eq("gnt",    32'(gnt),    32'(e_gnt));
        check_eq("rvalid", 32'(rvalid), 32'(e_rvalid));
        check_eq("rdata1", rdata1,      e_rdata1);
        check_eq("rdata2", rdata2,      e_rdata2);
        check_eq("busy",   32'(busy),   32'(e_busy));
        check_eq("x_we",   32'(x_we),   32'(e_xwe));
        check_eq("x_rd",   32'(x_rd),   32'(e_xrd));
        check_eq("x_rs1",  32'(x_rs1),  32'(e_xrs1));
        check_eq("x_rs2",  32'(x_rs2),  32'(e_xrs2));
        check_eq("x_in",   x_in,        e_xin);
`ifdef REGFILE_ARB_STATS_EN
        check_eq("grant_cnt",    gcnt, m_grants);
        check_eq("conflict_cnt", ccnt, m_conflicts);
`endif
    endtask

    task automatic policy();
        logic [2:0] kk;
        for (int k = 0; k < N; k++) begin
            kk = 3'(k);
            if (gnt[kk]) begin
                req[kk] = 1'b0;
                rearm[k] = rearm_en ? 2 : 0;
            end else if (rearm[k] > 0) begin
                rearm[k]--;
                if (rearm[k] == 0) req[kk] = 1'b1;
            end else if (rand_en) begin
                if (!req[kk] && $urandom_range(99) < 32'd30) begin
                    we[kk]    = 1'($urandom_range(1));
                    rd_a[kk]  = ($urandom_range(3) == 32'd0) ? 5'd0 : 5'($urandom_range(31));
                    rs1_a[kk] = 5'($urandom_range(31));
                    rs2_a[kk] = 5'($urandom_range(31));
                    wd_a[kk]  = $urandom;
                    req[kk]   = 1'b1;
                end else if (req[kk] && $urandom_range(99) < 32'd4) begin
                    req[kk] = 1'b0;
                end
            end
        end
    endtask

    // One clock: predict, take the edge, apply the file write, check, react.
    task automatic step();
        predict();
        @(posedge CLK);
        pw_en = x_we; pw_a = x_rd; pw_d = x_in;
        @(negedge CLK);
        if (pw_en) rf[pw_a] = pw_d;
        compare();
        policy();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        req = '0; rand_en = 1'b0; rearm_en = 1'b0;
        for (int k = 0; k < N; k++) rearm[k] = 0;
        m_acc = 1'b0; m_resp = 1'b0; m_ptr = N - 1; m_grants = 0; m_conflicts = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        check_eq("rst_gnt",    32'(gnt),    32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata1", rdata1,      32'd0);
        check_eq("rst_busy",   32'(busy),   32'd0);
        check_eq("rst_x_we",   32'(x_we),   32'd0);
        check_eq("rst_x_rd",   32'(x_rd),   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] old9;
        for (int r = 0; r < 32; r++) begin
            v = (r == 0) ? 32'd0 : $urandom;
            rf[r] = v;
            ref_regs[r] = v;
        end
        for (int k = 0; k < N; k++) begin
            rd_a[k] = '0; rs1_a[k] = '0; rs2_a[k] = '0; wd_a[k] = '0; rearm[k] = 0;
        end
        we = '0; req = '0;
        do_reset();

        // single read from requester 0
        rf[3] = 32'hAA; ref_regs[3] = 32'hAA;
        rf[4] = 32'hBB; ref_regs[4] = 32'hBB;
        rs1_a[0] = 5'd3; rs2_a[0] = 5'd4; req = 6'b000001;
        step();
        check_eq("t1_gnt", 32'(gnt), 32'h1);
        step();
        check_eq("t1_rvalid", 32'(rvalid), 32'h1);
        check_eq("t1_rdata1", rdata1, 32'hAA);
        check_eq("t1_rdata2", rdata2, 32'hBB);
        step();

        // write to x0 is suppressed
        we[2] = 1'b1; rd_a[2] = 5'd0; wd_a[2] = 32'h1234; rs1_a[2] = 5'd0; req = 6'b000100;
        step();
        check_eq("t3_gnt", 32'(gnt), 32'h4);
        check_eq("t3_we_acc", 32'(x_we), 32'd0);
        step();
        check_eq("t3_we_resp", 32'(x_we), 32'd0);
        check_eq("t3_x0", rf[0], 32'd0);
        we[2] = 1'b0;
        step();

        // read-before-write on the same register, then read back
        rf[7] = 32'h5; ref_regs[7] = 32'h5;
        we[1] = 1'b1; rd_a[1] = 5'd7; rs1_a[1] = 5'd7; rs2_a[1] = 5'd0; wd_a[1] = 32'h9;
        req = 6'b000010;
        step();
        step();
        check_eq("t4_rdata1_old", rdata1, 32'h5);
        we[1] = 1'b0; req = 6'b000010;
        step();
        step();
        check_eq("t4_rdata1_new", rdata1, 32'h9);
        step();

        // full load: grants rotate 0..5,0 every other cycle
        do_reset();
        we = '0; rearm_en = 1'b1; req = 6'b111111;
        for (int i = 0; i < 14; i++) begin
            step();
            check_eq("t2_busy", 32'(busy), 32'd1);
            if (i % 2 == 0) check_eq("t2_order", 32'(gnt), 32'd1 << ((i / 2) % N));
        end
        rearm_en = 1'b0; req = '0;
        for (int k = 0; k < N; k++) rearm[k] = 0;
        repeat (3) step();

        // reset in the middle of a write access
        rf[9] = 32'h0BAD_0009; ref_regs[9] = 32'h0BAD_0009; old9 = rf[9];
        we[3] = 1'b1; rd_a[3] = 5'd9; wd_a[3] = 32'hDEAD_BEEF; req = 6'b001000;
        step();
        check_eq("t5_gnt_pre", 32'(gnt), 32'h8);
        RST_N = 1'b0;
        #1;
        check_eq("t5_gnt_drop", 32'(gnt), 32'd0);
        check_eq("t5_we_drop",  32'(x_we), 32'd0);
        do_reset();
        we = '0; req = 6'b111111;
        step();
        check_eq("t5_first_gnt", 32'(gnt), 32'h1);
        check_eq("t5_nowrite", rf[9], old9);
        repeat (12) step();

        // random traffic
        rand_en = 1'b1;
        repeat (400) step();
        rand_en = 1'b0; req = '0;
        repeat (3) step();

`ifdef REGFILE_ARB_STATS_EN
        do_reset();
        we = '0; req = 6'b010101;
        repeat (6) step();
        check_eq("t6_grant_cnt",    gcnt, 32'd3);
        check_eq("t6_conflict_cnt", ccnt, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
